// File: rtl/ber_checker.sv
// Bit-error-rate checker: slices the filtered RX stream once per symbol, sweeps every
// candidate reference delay over a fixed window, then locks on the best one and counts errors.
module ber_checker #(
   parameter int N_OS   = 4,
   parameter int NB_I   = 9,
   parameter int NB_DLY = 5,
   parameter int WIN    = 511,
   parameter int NB_CNT = 32,
   localparam int NB_PH = (N_OS > 1) ? $clog2(N_OS) : 1
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_enable,
   input  logic                   i_ref_bit,
   input  logic signed [NB_I-1:0] i_rx_sample,
   input  logic [NB_PH-1:0]       i_phase,
   input  logic                   i_resync,
   output logic                   o_lock,
   output logic [NB_DLY-1:0]      o_best_delay,
   output logic [NB_CNT-1:0]      o_err_count,
   output logic [NB_CNT-1:0]      o_bit_count
);
   // state | meaning
   // FILL  | refilling the reference delay line after reset or resync
   // SWEEP | scoring one candidate delay per window of WIN decisions
   // LOCK  | comparing at o_best_delay and accumulating error/bit counts

   localparam int                DMAX     = 1 << NB_DLY;
   localparam int                NB_WIN   = $clog2(WIN + 1);
   localparam logic [NB_PH-1:0]  PH_LAST  = NB_PH'(N_OS - 1);
   localparam logic [NB_WIN-1:0] WIN_LAST = NB_WIN'(WIN);
   localparam logic [NB_DLY-1:0] DLY_LAST = '1;

   typedef enum logic [1:0] {FILL, SWEEP, LOCK} state_t;

   state_t            state;
   logic [NB_PH-1:0]  phase_cnt;
   logic              dec_bit;
   logic              dec_valid;
   logic [DMAX-1:0]   dly_line;
   logic [NB_DLY-1:0] fill_cnt;
   logic [NB_DLY-1:0] cur_delay;
   logic [NB_DLY-1:0] best_delay;
   logic [NB_WIN-1:0] win_cnt;
   logic [NB_WIN-1:0] win_err;
   logic [NB_WIN-1:0] best_err;

   logic [NB_DLY-1:0] sel_delay;
   logic              mismatch;
   logic [NB_WIN-1:0] win_cnt_nxt;
   logic [NB_WIN-1:0] win_err_nxt;
   logic              win_done;
   logic              take;
   logic [NB_DLY-1:0] best_delay_nxt;
   logic [NB_WIN-1:0] best_err_nxt;

   // only the sign bit feeds the slicer
   logic unused_rx;
   assign unused_rx = ^i_rx_sample[NB_I-2:0];

   always_comb begin
      sel_delay      = (state == LOCK) ? o_best_delay : cur_delay;
      mismatch       = dec_bit ^ dly_line[sel_delay];
      win_cnt_nxt    = win_cnt + 1'b1;
      win_err_nxt    = win_err + {{(NB_WIN-1){1'b0}}, mismatch};
      win_done       = (win_cnt_nxt == WIN_LAST);
      take           = (cur_delay == '0) || (win_err_nxt < best_err);
      best_delay_nxt = take ? cur_delay : best_delay;
      best_err_nxt   = take ? win_err_nxt : best_err;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         phase_cnt <= '0;
         dec_bit   <= 1'b0;
         dec_valid <= 1'b0;
         dly_line  <= '0;
      end else begin
         if (i_enable)
            phase_cnt <= '0;
         else if (phase_cnt == PH_LAST)
            phase_cnt <= '0;
         else
            phase_cnt <= phase_cnt + 1'b1;
         dec_valid <= (phase_cnt == i_phase);
         if (phase_cnt == i_phase)
            dec_bit <= i_rx_sample[NB_I-1];
         if (i_enable)
            dly_line <= {dly_line[DMAX-2:0], i_ref_bit};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state        <= FILL;
         fill_cnt     <= '0;
         cur_delay    <= '0;
         best_delay   <= '0;
         win_cnt      <= '0;
         win_err      <= '0;
         best_err     <= '0;
         o_lock       <= 1'b0;
         o_best_delay <= '0;
         o_err_count  <= '0;
         o_bit_count  <= '0;
      end else if (i_resync) begin
         // o_best_delay deliberately survives until the next sweep finishes
         state       <= FILL;
         fill_cnt    <= '0;
         cur_delay   <= '0;
         win_cnt     <= '0;
         win_err     <= '0;
         best_err    <= '0;
         o_lock      <= 1'b0;
         o_err_count <= '0;
         o_bit_count <= '0;
      end else begin
         case (state)
            FILL: begin
               if (i_enable) begin
                  fill_cnt <= fill_cnt + 1'b1;
                  if (fill_cnt == DLY_LAST) begin
                     state     <= SWEEP;
                     cur_delay <= '0;
                     win_cnt   <= '0;
                     win_err   <= '0;
                  end
               end
            end
            SWEEP: begin
               if (dec_valid) begin
                  if (win_done) begin
                     best_err   <= best_err_nxt;
                     best_delay <= best_delay_nxt;
                     win_cnt    <= '0;
                     win_err    <= '0;
                     if (cur_delay == DLY_LAST) begin
                        state        <= LOCK;
                        o_lock       <= 1'b1;
                        o_best_delay <= best_delay_nxt;
                     end else begin
                        cur_delay <= cur_delay + 1'b1;
                     end
                  end else begin
                     win_cnt <= win_cnt_nxt;
                     win_err <= win_err_nxt;
                  end
               end
            end
            LOCK: begin
               if (dec_valid) begin
                  if (o_bit_count != '1)
                     o_bit_count <= o_bit_count + 1'b1;
                  if (mismatch && (o_err_count != '1))
                     o_err_count <= o_err_count + 1'b1;
               end
            end
            default: state <= FILL;
         endcase
      end
   end
endmodule

// File: tb/tb_ber_checker.sv
// Bench for ber_checker: PRBS9 loopback with a known symbol delay, scoreboarded error/bit counts,
// plus a 4-bit-counter instance for saturation.
module tb_ber_checker;
   localparam int N_OS   = 4;
   localparam int NB_I   = 9;
   localparam int NB_DLY = 5;
   localparam int WIN    = 63;
   localparam int NB_CNT = 32;
   localparam int NB_SAT = 4;
   localparam int DMAX   = 1 << NB_DLY;
   localparam int SWEEP_DECS = DMAX * WIN;

   logic clk = 1'b0;
   logic rst, enable, ref_bit, resync;
   logic signed [NB_I-1:0] rx1, rx2;
   logic [1:0] phase;
   logic lock1, lock2;
   logic [NB_DLY-1:0] best1, best2;
   logic [NB_CNT-1:0] err1, bits1;
   logic [NB_SAT-1:0] err2, bits2;

   always #5 clk = ~clk;

   ber_checker #(.N_OS(N_OS), .NB_I(NB_I), .NB_DLY(NB_DLY), .WIN(WIN), .NB_CNT(NB_CNT)) dut (
      .i_clk(clk), .i_reset(rst), .i_enable(enable), .i_ref_bit(ref_bit),
      .i_rx_sample(rx1), .i_phase(phase), .i_resync(resync),
      .o_lock(lock1), .o_best_delay(best1), .o_err_count(err1), .o_bit_count(bits1));

   ber_checker #(.N_OS(N_OS), .NB_I(NB_I), .NB_DLY(NB_DLY), .WIN(WIN), .NB_CNT(NB_SAT)) dut_sat (
      .i_clk(clk), .i_reset(rst), .i_enable(enable), .i_ref_bit(ref_bit),
      .i_rx_sample(rx2), .i_phase(phase), .i_resync(resync),
      .o_lock(lock2), .o_best_delay(best2), .o_err_count(err2), .o_bit_count(bits2));

   int tests = 0;
   int fails = 0;

   typedef struct {longint errs; longint bits;} exp_t;
   exp_t exp_q[$];

   typedef enum {M_FILL, M_SWEEP, M_LOCK} mstate_t;
   mstate_t mstate;
   int      m_fill, m_decs, m_ph;
   longint  m_bits, m_errs;
   bit      m_lock, m_pend, m_pend_ok;
   bit      ref_hist[$];
   int      dly;
   bit      p3only;
   logic [8:0] prbs;
   longint  e0, b0, mb0;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_counts();
      if (m_bits != 0) exp_q.push_back('{0, 0});
      m_bits = 0;
      m_errs = 0;
   endtask

   // Reference model: decisions are counted once locked; a decision is wrong exactly
   // when the sampled RX cycle did not carry the correctly delayed reference symbol.
   task automatic model_update(input bit strobe, input bit rs, input bit ok);
      bit dec, dec_ok;
      dec       = m_pend;
      dec_ok    = m_pend_ok;
      m_pend    = (m_ph == int'(phase));
      m_pend_ok = ok;
      m_ph      = strobe ? 0 : (m_ph + 1) % N_OS;
      if (rs) begin
         mstate = M_FILL;
         m_fill = 0;
         m_decs = 0;
         clear_counts();
      end else begin
         case (mstate)
            M_FILL: if (strobe) begin
               m_fill++;
               if (m_fill == DMAX) begin mstate = M_SWEEP; m_decs = 0; end
            end
            M_SWEEP: if (dec) begin
               m_decs++;
               if (m_decs == SWEEP_DECS) mstate = M_LOCK;
            end
            M_LOCK: if (dec) begin
               m_bits++;
               if (!dec_ok) m_errs++;
               exp_q.push_back('{m_errs, m_bits});
            end
            default: mstate = M_FILL;
         endcase
      end
      m_lock = (mstate == M_LOCK);
   endtask

   task automatic cycle(input bit strobe, input bit inv1, input bit inv2, input bit rs);
      bit nominal, ok1, v1;
      int k;
      rst    = 1'b0;
      enable = strobe;
      resync = rs;
      if (strobe) begin
         ref_bit = prbs[8] ^ prbs[4];
         prbs    = {prbs[7:0], prbs[8] ^ prbs[4]};
         ref_hist.push_back(ref_bit);
      end else begin
         ref_bit = 1'($urandom_range(0, 1));
      end
      k       = ref_hist.size() - 1;
      nominal = (k >= dly) ? ref_hist[k - dly] : 1'b0;
      ok1     = p3only ? strobe : !inv1;
      v1      = nominal ^ !ok1;
      rx1     = v1 ? -9'sd100 : 9'sd100;
      rx2     = (v1 ^ inv2) ? -9'sd100 : 9'sd100;
      model_update(strobe, rs, ok1);
      @(posedge clk);
      #1;
      chk("lock", lock1, m_lock);
      chk("lock_sat", lock2, m_lock);
   endtask

   task automatic symbol(input bit inv1, input bit inv2);
      for (int i = 0; i < N_OS; i++) cycle(i == 0, inv1, inv2, 1'b0);
   endtask

   task automatic reset_cycle();
      rst     = 1'b1;
      enable  = 1'($urandom_range(0, 1));
      ref_bit = 1'($urandom_range(0, 1));
      resync  = 1'($urandom_range(0, 1));
      phase   = 2'($urandom_range(0, 3));
      rx1     = NB_I'($urandom);
      rx2     = NB_I'($urandom);
      mstate  = M_FILL;
      m_fill  = 0;
      m_decs  = 0;
      m_ph    = 0;
      m_pend  = 1'b0;
      m_pend_ok = 1'b1;
      m_lock  = 1'b0;
      clear_counts();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every change of the bit counter consumes one expected entry.
   initial begin
      longint prev_bits;
      exp_t e;
      prev_bits = 0;
      forever begin
         @(negedge clk);
         if (longint'(bits1) != prev_bits) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_bits", bits1, prev_bits);
            end else begin
               e = exp_q.pop_front();
               chk("sb_bits", bits1, e.bits);
               chk("sb_errs", err1, e.errs);
            end
            prev_bits = longint'(bits1);
         end
      end
   end

   initial begin
      int n;
      int j;
      m_bits = 0;
      m_errs = 0;
      prbs   = 9'($urandom_range(1, 511));
      dly    = 7;
      p3only = 1'b0;
      repeat (3) reset_cycle();
      chk("rst_lock", lock1, 0);
      chk("rst_best", best1, 0);
      chk("rst_err", err1, 0);
      chk("rst_bits", bits1, 0);
      chk("rst_sat_lock", lock2, 0);
      chk("rst_sat_err", err2, 0);
      chk("rst_sat_bits", bits2, 0);
      phase  = 2'd2;

      // Loopback at delay 7, sampling phase 2
      n = 0;
      while (!m_lock && n < 4000) begin symbol(1'b0, 1'b0); n++; end
      chk("lock_up", lock1, 1);
      chk("best_delay_7", best1, 7);
      chk("sat_best_delay_7", best2, 7);

      // Saturation instance sees every locked symbol inverted
      repeat (30) symbol(1'b0, 1'b1);
      chk("sat_err", err2, 15);
      chk("sat_bits", bits2, 15);
      repeat (470) symbol(1'b0, 1'b0);
      chk("sat_err_hold", err2, 15);
      chk("sat_bits_hold", bits2, 15);
      chk("clean_err", err1, 0);

      // One inverted symbol in every block of 100
      e0 = longint'(err1);
      b0 = longint'(bits1);
      for (int blk = 0; blk < 20; blk++) begin
         j = $urandom_range(0, 98);
         for (int s = 0; s < 100; s++) symbol(s == j, 1'b0);
      end
      chk("inject_err_delta", longint'(err1) - e0, 20);
      chk("inject_bit_delta", longint'(bits1) - b0, 2000);

      // Resync while locked; new stimulus at delay 12, RX valid only at phase 3
      dly    = 12;
      p3only = 1'b1;
      phase  = 2'd3;
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      chk("resync_err", err1, 0);
      chk("resync_bits", bits1, 0);
      chk("resync_best_hold", best1, 7);
      for (int i = 1; i < N_OS; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n = 0;
      while (!m_lock && n < 4000) begin symbol(1'b0, 1'b0); n++; end
      chk("relock", lock1, 1);
      chk("best_delay_12", best1, 12);
      e0 = longint'(err1);
      b0 = longint'(bits1);
      repeat (300) symbol(1'b0, 1'b0);
      chk("phase3_err_delta", longint'(err1) - e0, 0);
      chk("phase3_bit_delta", longint'(bits1) - b0, 300);

      // Same stimulus sampled at phase 1: every decision is wrong
      phase = 2'd1;
      e0  = longint'(err1);
      b0  = longint'(bits1);
      mb0 = m_bits;
      repeat (300) symbol(1'b0, 1'b0);
      chk("phase1_err_eq_bits", longint'(err1) - e0, longint'(bits1) - b0);
      chk("phase1_bit_delta", longint'(bits1) - b0, m_bits - mb0);

      // Reset while locked discards everything
      reset_cycle();
      chk("midrst_lock", lock1, 0);
      chk("midrst_best", best1, 0);
      chk("midrst_err", err1, 0);
      chk("midrst_bits", bits1, 0);
      phase  = 2'd2;
      dly    = 7;
      p3only = 1'b0;
      repeat (50) symbol(1'b0, 1'b0);
      repeat (4) @(posedge clk);
      chk("sb_drain", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
